// File: rtl/axis_mm_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// axis_mm_stream_ctrl_if
//
// Bundles every handshake / bus signal of axis_mm_stream_ctrl:
//   - s_axis_i_*  : input-matrix AXI-Stream (NUM_CORES chunks per beat)
//   - s_axis_w_*  : weight AXI-Stream (one chunk per beat)
//   - m_axis_*    : result AXI-Stream
//   - in_* / wb_* : write ports of the compute top's input / weight BRAMs
//   - top_start / top_done : compute handshake
//   - out_rd_*    : result read port of the compute top
//   - busy / err_tlast : status
//
// Modports:
//   master : the stream controller (drives treadys, BRAM writes, start,
//            result reads and the result stream)
//   slave  : the surrounding system (stream sources/sink, compute top)
// ---------------------------------------------------------------------------
interface axis_mm_stream_ctrl_if #(
    parameter int WIDTH       = 16,
    parameter int CHUNK_SIZE  = 4,
    parameter int NUM_CORES   = 2,
    parameter int NUM_I_WORDS = 8,
    parameter int NUM_W_WORDS = 12,
    parameter int NUM_O_WORDS = 6
);
    localparam int DW  = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int WW  = WIDTH * CHUNK_SIZE;
    localparam int IAW = (NUM_I_WORDS > 1) ? $clog2(NUM_I_WORDS) : 1;
    localparam int WAW = (NUM_W_WORDS > 1) ? $clog2(NUM_W_WORDS) : 1;
    localparam int OAW = (NUM_O_WORDS > 1) ? $clog2(NUM_O_WORDS) : 1;

    logic [DW-1:0]  s_axis_i_tdata;
    logic           s_axis_i_tvalid;
    logic           s_axis_i_tlast;
    logic           s_axis_i_tready;

    logic [WW-1:0]  s_axis_w_tdata;
    logic           s_axis_w_tvalid;
    logic           s_axis_w_tlast;
    logic           s_axis_w_tready;

    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready;

    logic           in_ena;
    logic [IAW-1:0] in_addra;
    logic [DW-1:0]  in_dina;

    logic           wb_ena;
    logic [WAW-1:0] wb_addra;
    logic [WW-1:0]  wb_dina;

    logic           top_start;
    logic           top_done;

    logic           out_rd_en;
    logic [OAW-1:0] out_rd_addr;
    logic [DW-1:0]  out_rd_data;

    logic           busy;
    logic           err_tlast;

    modport master (
        input  s_axis_i_tdata, s_axis_i_tvalid, s_axis_i_tlast,
        output s_axis_i_tready,
        input  s_axis_w_tdata, s_axis_w_tvalid, s_axis_w_tlast,
        output s_axis_w_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output in_ena, in_addra, in_dina,
        output wb_ena, wb_addra, wb_dina,
        output top_start,
        input  top_done,
        output out_rd_en, out_rd_addr,
        input  out_rd_data,
        output busy, err_tlast
    );

    modport slave (
        output s_axis_i_tdata, s_axis_i_tvalid, s_axis_i_tlast,
        input  s_axis_i_tready,
        output s_axis_w_tdata, s_axis_w_tvalid, s_axis_w_tlast,
        input  s_axis_w_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  in_ena, in_addra, in_dina,
        input  wb_ena, wb_addra, wb_dina,
        input  top_start,
        output top_done,
        input  out_rd_en, out_rd_addr,
        output out_rd_data,
        input  busy, err_tlast
    );
endinterface

// File: rtl/axis_mm_stream_ctrl.sv
// ---------------------------------------------------------------------------
// axis_mm_stream_ctrl
//
// AXI-Stream front/back-end for the matrix-multiply top. Each frame:
//   IDLE  -> one arming cycle
//   LOAD  -> input and weight beats are written straight into the top's
//            BRAM ports (independent streams, count-terminated)
//   START -> one-cycle top_start pulse
//   WAIT  -> wait for top_done
//   DRAIN -> read NUM_O_WORDS result words through a skid FIFO and stream
//            them out with full backpressure and tlast on the last beat
// Frames repeat back-to-back.
//
// Ports:
//   aclk   : clock
//   areset : asynchronous active-high reset
//   bus    : axis_mm_stream_ctrl_if.master (streams, BRAM ports, start/done,
//            result read port, busy, err_tlast)
//
// Optional feature macro: TLAST_CHECK_EN
//   defined   : a slave handshake whose tlast disagrees with the beat count
//               sets the sticky err_tlast flag
//   undefined : err_tlast is tied low and slave tlast inputs are ignored
// ---------------------------------------------------------------------------
module axis_mm_stream_ctrl #(
    parameter int WIDTH       = 16,
    parameter int CHUNK_SIZE  = 4,
    parameter int NUM_CORES   = 2,
    parameter int NUM_I_WORDS = 8,
    parameter int NUM_W_WORDS = 12,
    parameter int NUM_O_WORDS = 6,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    axis_mm_stream_ctrl_if.master bus
);
    localparam int DW    = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int IAW   = (NUM_I_WORDS > 1) ? $clog2(NUM_I_WORDS) : 1;
    localparam int WAW   = (NUM_W_WORDS > 1) ? $clog2(NUM_W_WORDS) : 1;
    localparam int OAW   = (NUM_O_WORDS > 1) ? $clog2(NUM_O_WORDS) : 1;
    localparam int ICW   = $clog2(NUM_I_WORDS + 1);
    localparam int WCW   = $clog2(NUM_W_WORDS + 1);
    localparam int OCW   = $clog2(NUM_O_WORDS + 1);
    // One slot per read that can be in flight plus one so a full-rate
    // stream never has to stall while a beat sits at the output.
    localparam int DEPTH = RD_LATENCY + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int FCW   = $clog2(DEPTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]            state_reg, state_next;
    logic [ICW-1:0]        cnt_i_reg;
    logic [WCW-1:0]        cnt_w_reg;
    logic [OCW-1:0]        rd_cnt_reg;
    logic [OCW-1:0]        out_cnt_reg;
    logic [FCW-1:0]        inflight_reg;
    logic [FCW-1:0]        fifo_cnt_reg;
    logic [RD_LATENCY-1:0] ret_pipe_reg;
    logic [PW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [DW-1:0]         fifo_mem [DEPTH];

    logic in_load, in_drain;
    logic i_ready, w_ready, i_hs, w_hs, load_done;
    logic out_valid, push, pop, last_beat, rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- load side ----------------
    assign in_load   = (state_reg == S_LOAD);
    assign i_ready   = in_load && (cnt_i_reg < ICW'(NUM_I_WORDS));
    assign w_ready   = in_load && (cnt_w_reg < WCW'(NUM_W_WORDS));
    assign i_hs      = i_ready && bus.s_axis_i_tvalid;
    assign w_hs      = w_ready && bus.s_axis_w_tvalid;
    // Counts that will be reached at this edge, so the final beats of both
    // streams landing in the same cycle still move straight to START.
    assign load_done = in_load
                    && ((cnt_i_reg + ICW'(i_hs)) == ICW'(NUM_I_WORDS))
                    && ((cnt_w_reg + WCW'(w_hs)) == WCW'(NUM_W_WORDS));

    // ---------------- drain side ----------------
    assign in_drain  = (state_reg == S_DRAIN);
    assign out_valid = (fifo_cnt_reg != '0);
    assign pop       = out_valid && bus.m_axis_tready;
    assign push      = ret_pipe_reg[RD_LATENCY-1];
    assign last_beat = (out_cnt_reg == OCW'(NUM_O_WORDS - 1));
    // A read may be issued only if its data is guaranteed a FIFO slot when
    // it returns; a beat leaving this cycle frees its slot in time.
    assign rd_en     = in_drain && (rd_cnt_reg < OCW'(NUM_O_WORDS))
                    && ((int'(inflight_reg) + int'(fifo_cnt_reg) - int'(pop)) < DEPTH);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = S_LOAD;
            S_LOAD:  if (load_done) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT:  if (bus.top_done) state_next = S_DRAIN;
            S_DRAIN: if (pop && last_beat) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg    <= S_IDLE;
            cnt_i_reg    <= '0;
            cnt_w_reg    <= '0;
            rd_cnt_reg   <= '0;
            out_cnt_reg  <= '0;
            inflight_reg <= '0;
            fifo_cnt_reg <= '0;
            ret_pipe_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;

            if (load_done) begin
                cnt_i_reg <= '0;
                cnt_w_reg <= '0;
            end else begin
                cnt_i_reg <= cnt_i_reg + ICW'(i_hs);
                cnt_w_reg <= cnt_w_reg + WCW'(w_hs);
            end

            // Tracks which cycles carry returning read data.
            ret_pipe_reg <= (ret_pipe_reg << 1) | RD_LATENCY'(rd_en);
            inflight_reg <= inflight_reg + FCW'(rd_en) - FCW'(push);
            fifo_cnt_reg <= fifo_cnt_reg + FCW'(push) - FCW'(pop);
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);

            if (pop && last_beat) begin
                rd_cnt_reg  <= '0;
                out_cnt_reg <= '0;
            end else begin
                rd_cnt_reg  <= rd_cnt_reg + OCW'(rd_en);
                out_cnt_reg <= out_cnt_reg + OCW'(pop);
            end
        end
    end

    // Skid FIFO storage; contents are only observed while the count says so.
    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr_reg] <= bus.out_rd_data;
    end

`ifdef TLAST_CHECK_EN
    logic err_reg;
    logic i_bad, w_bad;
    assign i_bad = i_hs && (bus.s_axis_i_tlast != (cnt_i_reg == ICW'(NUM_I_WORDS - 1)));
    assign w_bad = w_hs && (bus.s_axis_w_tlast != (cnt_w_reg == WCW'(NUM_W_WORDS - 1)));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) err_reg <= 1'b0;
        else        err_reg <= err_reg | i_bad | w_bad;
    end
    assign bus.err_tlast = err_reg;
`else
    logic unused_tlast;
    assign unused_tlast  = bus.s_axis_i_tlast | bus.s_axis_w_tlast;
    assign bus.err_tlast = 1'b0;
`endif

    // ---------------- outputs ----------------
    // Data/address are gated with their enables so every output is zero
    // while nothing is being transferred (including throughout reset).
    assign bus.s_axis_i_tready = i_ready;
    assign bus.s_axis_w_tready = w_ready;
    assign bus.in_ena          = i_hs;
    assign bus.in_addra        = i_hs ? cnt_i_reg[IAW-1:0] : '0;
    assign bus.in_dina         = i_hs ? bus.s_axis_i_tdata : '0;
    assign bus.wb_ena          = w_hs;
    assign bus.wb_addra        = w_hs ? cnt_w_reg[WAW-1:0] : '0;
    assign bus.wb_dina         = w_hs ? bus.s_axis_w_tdata : '0;
    assign bus.top_start       = (state_reg == S_START);
    assign bus.out_rd_en       = rd_en;
    assign bus.out_rd_addr     = rd_en ? rd_cnt_reg[OAW-1:0] : '0;
    assign bus.m_axis_tvalid   = out_valid;
    assign bus.m_axis_tdata    = out_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign bus.m_axis_tlast    = out_valid && last_beat;
    assign bus.busy            = (state_reg != S_IDLE);
endmodule

// File: tb/tb_axis_mm_stream_ctrl.sv
`timescale 1ns/1ps
module tb_axis_mm_stream_ctrl;
    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int CORES = 2;
    localparam int NI    = 8;
    localparam int NW    = 12;
    localparam int NO    = 6;
    localparam int RDL   = 3;
    localparam int DW    = WIDTH * CHUNK * CORES;
    localparam int WW    = WIDTH * CHUNK;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axis_mm_stream_ctrl_if #(
        .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK), .NUM_CORES(CORES),
        .NUM_I_WORDS(NI), .NUM_W_WORDS(NW), .NUM_O_WORDS(NO)
    ) bus ();

    axis_mm_stream_ctrl #(
        .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK), .NUM_CORES(CORES),
        .NUM_I_WORDS(NI), .NUM_W_WORDS(NW), .NUM_O_WORDS(NO),
        .RD_LATENCY(RDL)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference expectations
    int            i_addr_q[$];
    logic [DW-1:0] i_data_q[$];
    int            w_addr_q[$];
    logic [WW-1:0] w_data_q[$];
    logic [DW-1:0] o_data_q[$];
    bit            o_last_q[$];
    int            i_hs_cnt, w_hs_cnt, start_cnt, out_hs_cnt;
    int            err_exp = 0;
    int            rdy_mode = 0;

    // Behavioural result memory of the compute top
    logic [DW-1:0] res_mem [8];
    logic [DW-1:0] rd_pipe [RDL];

    always @(posedge aclk) begin
        rd_pipe[0] <= bus.out_rd_en ? res_mem[bus.out_rd_addr] : '0;
        for (int p = 1; p < RDL; p++) rd_pipe[p] <= rd_pipe[p-1];
    end
    assign bus.out_rd_data = rd_pipe[RDL-1];

    function automatic void check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    function automatic void check_dw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < DW / 32; k++) r = {r[DW-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic tick(inout int n, input string what);
        @(posedge aclk); #1;
        n++;
        if (n > 3000) begin
            $display("FAIL timeout_%s actual=%0d required=<3000", what, n);
            $fatal(1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_int({tag, "_ctrl_bits"},
                  int'({bus.s_axis_i_tready, bus.s_axis_w_tready, bus.m_axis_tvalid,
                        bus.m_axis_tlast, bus.in_ena, bus.wb_ena, bus.top_start,
                        bus.out_rd_en, bus.busy, bus.err_tlast}), 0);
        check_dw({tag, "_tdata"}, bus.m_axis_tdata, '0);
        check_dw({tag, "_in_dina"}, bus.in_dina, '0);
        check_int({tag, "_addrs"}, int'({bus.in_addra, bus.wb_addra, bus.out_rd_addr}), 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [DW-1:0] prev_data;
    bit            prev_last;
    bit            prev_stall = 0;
    int            post_cnt = 0;

    initial begin
        logic [DW-1:0] exp_d;
        bit            exp_l;
        forever begin
            @(negedge aclk);
            if (areset) begin
                prev_stall = 0;
                post_cnt   = 0;
            end else begin
                if (post_cnt == 2) begin
                    check_int("rearm_load_i_tready", int'(bus.s_axis_i_tready), 1);
                    post_cnt = 0;
                end
                if (post_cnt == 1) begin
                    check_int("busy_after_last", int'(bus.busy), 0);
                    post_cnt = 2;
                end
                if (bus.in_ena) begin
                    if (i_addr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_in_write actual=addr%0d required=none", bus.in_addra);
                    end else begin
                        check_int("in_addra", int'(bus.in_addra), i_addr_q.pop_front());
                        check_dw("in_dina", bus.in_dina, i_data_q.pop_front());
                    end
                    i_hs_cnt++;
                end
                if (bus.wb_ena) begin
                    if (w_addr_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_wb_write actual=addr%0d required=none", bus.wb_addra);
                    end else begin
                        check_int("wb_addra", int'(bus.wb_addra), w_addr_q.pop_front());
                        check_dw("wb_dina", DW'(bus.wb_dina), DW'(w_data_q.pop_front()));
                    end
                    w_hs_cnt++;
                end
                if (bus.top_start) begin
                    start_cnt++;
                    check_int("start_after_all_i", i_hs_cnt, NI);
                    check_int("start_after_all_w", w_hs_cnt, NW);
                end
                if (prev_stall) begin
                    check_int("stall_tvalid_held", int'(bus.m_axis_tvalid), 1);
                    check_dw("stall_tdata_held", bus.m_axis_tdata, prev_data);
                    check_int("stall_tlast_held", int'(bus.m_axis_tlast), int'(prev_last));
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (o_data_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_out_beat actual=%h required=none", bus.m_axis_tdata);
                    end else begin
                        exp_d = o_data_q.pop_front();
                        exp_l = o_last_q.pop_front();
                        check_dw("out_tdata", bus.m_axis_tdata, exp_d);
                        check_int("out_tlast", int'(bus.m_axis_tlast), int'(exp_l));
                        if (exp_l) post_cnt = 1;
                    end
                    out_hs_cnt++;
                end
                prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_data  = bus.m_axis_tdata;
                prev_last  = bus.m_axis_tlast;
            end
        end
    end

    // ---------------- compute-top done responder ----------------
    initial begin
        bus.top_done = 1'b0;
        forever begin
            @(negedge aclk);
            if (bus.top_start && !areset) begin
                repeat (5) @(posedge aclk);
                #1 bus.top_done = 1'b1;
                @(posedge aclk);
                #1 bus.top_done = 1'b0;
            end
        end
    end

    // ---------------- downstream ready ----------------
    initial begin
        int cyc = 0;
        bus.m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            case (rdy_mode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: bus.m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
    end

    // ---------------- stream drivers ----------------
    task automatic drive_i(input int bad_pos);
        logic [DW-1:0] d;
        bit hs;
        int n;
        for (int k = 0; k < NI; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            d = rand_dw();
            bus.s_axis_i_tvalid = 1'b1;
            bus.s_axis_i_tdata  = d;
            bus.s_axis_i_tlast  = (k == NI - 1) || (k == bad_pos);
            i_addr_q.push_back(k);
            i_data_q.push_back(d);
            hs = 0; n = 0;
            while (!hs) begin
                @(negedge aclk);
                hs = bus.s_axis_i_tready;
                tick(n, "i_beat");
            end
            bus.s_axis_i_tvalid = 1'b0;
            bus.s_axis_i_tlast  = 1'b0;
            bus.s_axis_i_tdata  = '0;
            if (k == bad_pos) begin
`ifdef TLAST_CHECK_EN
                err_exp = 1;
`endif
                @(negedge aclk);
                check_int("err_tlast_next_cycle", int'(bus.err_tlast), err_exp);
                @(posedge aclk); #1;
            end
        end
    endtask

    task automatic drive_w(input bit stall);
        logic [WW-1:0] d;
        bit hs;
        int n;
        if (stall) begin
            n = 0;
            while (i_hs_cnt < NI) tick(n, "w_stall");
            @(negedge aclk);
            check_int("i_tready_after_full", int'(bus.s_axis_i_tready), 0);
            check_int("no_start_before_w", start_cnt, 0);
            @(posedge aclk); #1;
        end
        for (int k = 0; k < NW; k++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
            d = WW'($urandom()) << 32 | WW'($urandom());
            bus.s_axis_w_tvalid = 1'b1;
            bus.s_axis_w_tdata  = d;
            bus.s_axis_w_tlast  = (k == NW - 1);
            w_addr_q.push_back(k);
            w_data_q.push_back(d);
            hs = 0; n = 0;
            while (!hs) begin
                @(negedge aclk);
                hs = bus.s_axis_w_tready;
                tick(n, "w_beat");
            end
            bus.s_axis_w_tvalid = 1'b0;
            bus.s_axis_w_tlast  = 1'b0;
            bus.s_axis_w_tdata  = '0;
        end
    endtask

    task automatic do_frame(input bit stall_w, input int bad_pos, input int rmode, input bit rst_mid);
        int n;
        rdy_mode = rmode;
        for (int a = 0; a < NO; a++) begin
            res_mem[a] = rand_dw();
            o_data_q.push_back(res_mem[a]);
            o_last_q.push_back(a == NO - 1);
        end
        i_hs_cnt = 0; w_hs_cnt = 0; start_cnt = 0; out_hs_cnt = 0;
        fork
            drive_i(bad_pos);
            drive_w(stall_w);
        join
        n = 0;
        if (rst_mid) begin
            while (out_hs_cnt < 2) tick(n, "drain_two");
            #2 areset = 1'b1;
            #1 check_all_zero("reset_in_drain");
            o_data_q.delete();
            o_last_q.delete();
            err_exp = 0;
            repeat (2) @(posedge aclk);
            #1 areset = 1'b0;
        end else begin
            while (o_data_q.size() != 0) tick(n, "frame_out");
            check_int("start_pulses", start_cnt, 1);
            check_int("out_beats", out_hs_cnt, NO);
            check_int("err_tlast_frame_end", int'(bus.err_tlast), err_exp);
        end
        $display("frame done: stall_w=%0d bad_tlast=%0d ready_mode=%0d reset_mid=%0d checks=%0d",
                 stall_w, bad_pos, rmode, rst_mid, checks);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        areset              = 1'b1;
        bus.s_axis_i_tvalid = 1'b0;
        bus.s_axis_i_tlast  = 1'b0;
        bus.s_axis_i_tdata  = '0;
        bus.s_axis_w_tvalid = 1'b0;
        bus.s_axis_w_tlast  = 1'b0;
        bus.s_axis_w_tdata  = '0;
        for (int a = 0; a < 8; a++) res_mem[a] = '0;
        repeat (2) @(negedge aclk);
        check_all_zero("reset");
        @(posedge aclk); #1 areset = 1'b0;

        do_frame(1'b0, -1, 0, 1'b0);   // nominal frame, ready held high
        do_frame(1'b1, -1, 0, 1'b0);   // weights held off until inputs complete
        do_frame(1'b0, -1, 1, 1'b0);   // ready pattern 1,0,0,1
        do_frame(1'b0,  4, 2, 1'b0);   // early input tlast, random ready
        do_frame(1'b0, -1, 0, 1'b1);   // reset in the middle of the drain
        do_frame(1'b0, -1, 0, 1'b0);   // full frame from address 0 after reset
        do_frame(1'b0, -1, 2, 1'b0);   // back-to-back, random ready

        repeat (5) @(posedge aclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_mm_stream_ctrl.md
Name: axis_mm_stream_ctrl

Overview:
Parametrised AXI-Stream front/back-end for the matrix-multiply top. Accepts an input-matrix stream (NUM_CORES chunks per beat) and a weight stream, and writes each beat into the top's input and weight BRAM ports. It then pulses start, waits for done, reads the result words from the top, and streams them out with full backpressure and tlast. Successor of the fixed-size FIFO/FSM wrapper: sizes, core count and output read latency are generic, the output path is backpressure-safe, and frames repeat back-to-back.

Parameters:
WIDTH, 16, bits per fixed-point element
CHUNK_SIZE, 4, elements per chunk (one 2x2 block)
NUM_CORES, 2, chunks per input/output beat
NUM_I_WORDS, 8, input beats per frame (>=1)
NUM_W_WORDS, 12, weight beats per frame (>=1)
NUM_O_WORDS, 6, output beats per frame (>=1)
RD_LATENCY, 1, cycles from out_rd_en to valid out_rd_data (1..4)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
s_axis_i_tdata  in  WIDTH*CHUNK_SIZE*NUM_CORES  input-matrix beat
s_axis_i_tvalid / s_axis_i_tlast  in  1  input-stream valid / last
s_axis_i_tready  out  1  input-stream ready
s_axis_w_tdata  in  WIDTH*CHUNK_SIZE  weight beat
s_axis_w_tvalid / s_axis_w_tlast  in  1  weight-stream valid / last
s_axis_w_tready  out  1  weight-stream ready
m_axis_tdata  out  WIDTH*CHUNK_SIZE*NUM_CORES  result beat
m_axis_tvalid / m_axis_tlast  out  1  result valid / last
m_axis_tready  in  1  downstream ready
in_ena  out  1  input-BRAM write enable
in_addra  out  clog2(NUM_I_WORDS) (min 1)  input-BRAM address
in_dina  out  WIDTH*CHUNK_SIZE*NUM_CORES  input-BRAM data
wb_ena  out  1  weight-BRAM write enable
wb_addra  out  clog2(NUM_W_WORDS) (min 1)  weight-BRAM address
wb_dina  out  WIDTH*CHUNK_SIZE  weight-BRAM data
top_start  out  1  one-cycle compute start pulse
top_done  in  1  compute finished (level or pulse)
out_rd_en  out  1  result read strobe
out_rd_addr  out  clog2(NUM_O_WORDS) (min 1)  result read address
out_rd_data  in  WIDTH*CHUNK_SIZE*NUM_CORES  result data, valid RD_LATENCY cycles after out_rd_en
busy  out  1  high in every state except IDLE
err_tlast  out  1  sticky framing error

Behaviour:
- One clock (aclk). Asynchronous, active-high reset (areset). While areset is high, all outputs are 0, the FSM is in IDLE, all counters are 0 and the skid buffer is empty. A reset mid-frame abandons the frame; no partial output is emitted.
- FSM states: IDLE -> LOAD -> START -> WAIT -> DRAIN -> IDLE.
- IDLE: tready outputs are 0. Goes to LOAD on the next cycle unconditionally (it is an arming state of one cycle).
- LOAD: the two streams are independent.
  - s_axis_i_tready = (cnt_i < NUM_I_WORDS); likewise for w.
  - On a handshake, the same cycle drives in_ena=1, in_addra=cnt_i, in_dina=tdata (combinational pass-through), and cnt_i increments. Same for the weight side.
  - When both counts are full (including the same cycle as the final beats), go to START and zero the counters.
- START: top_start=1 for exactly one cycle -> WAIT.
- WAIT: stay until top_done=1, then go to DRAIN. A top_done seen in any other state is ignored.
- DRAIN: reads are issued through a skid FIFO of depth RD_LATENCY+1.
  - out_rd_en=1 when rd_cnt < NUM_O_WORDS and (inflight + occupancy) < depth; out_rd_addr = rd_cnt.
  - Returned data is pushed into the FIFO RD_LATENCY cycles later.
  - m_axis_tvalid = FIFO not empty; m_axis_tlast is 1 on the NUM_O_WORDS-th beat only.
  - Once tvalid is high, tdata/tvalid/tlast stay stable until tready. A push and a pop in the same cycle are both honoured.
  - When the last beat handshakes, go to IDLE.
- Minimum latency from top_done to the first tvalid is 1 + RD_LATENCY cycles. With tready held high, throughput is 1 beat/cycle.
- Framing check: a handshake with tlast=1 at count != N-1, or tlast=0 at count == N-1, sets err_tlast. err_tlast stays set until reset. The frame still completes on count alone.

Optional Feature:
TLAST_CHECK_EN:
- Defined: the framing check above is implemented.
- Undefined: err_tlast is tied to 0, slave tlast inputs are ignored, and no check logic is synthesised.

Test Plan:
- Defaults, 8 input and 12 weight beats with proper tlast, top_done 5 cycles after start, tready=1 -> in_addra 0..7 and wb_addra 0..11 written once each; exactly one top_start pulse; 6 output beats at addresses 0..5 back-to-back, tlast on beat 6; busy falls after the last beat; err_tlast=0.
- Weight stream stalled until all 8 input beats are done -> s_axis_i_tready=0 after beat 8; START only after the 12th weight beat.
- RD_LATENCY=3, m_axis_tready toggling 1,0,0,1 -> no beat dropped or duplicated; output data equals the BRAM model in order; tdata stable while stalled.
- Input tlast asserted on beat 5 (TLAST_CHECK_EN defined) -> err_tlast=1 from the next cycle; the frame still loads 8 beats and completes. With the macro undefined, err_tlast stays 0.
- areset pulsed during DRAIN after 2 beats -> all outputs 0 immediately; a following full frame completes normally starting from address 0.
- Two frames back-to-back -> second frame's LOAD begins 2 cycles after the first tlast handshake; results correct for both frames.
